// File: rtl/gpio_apb_arbiter.sv
// Round-robin APB arbiter that shares one GPIO APB slave between NrMasters requesters.
// Optional ACCESS-phase timeout abort is enabled by defining GPIO_APB_ARB_TIMEOUT_EN.
module gpio_apb_arbiter #(
  parameter int NrMasters     = 2,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NrMasters-1:0]           mst_psel_i,
  input  logic [NrMasters-1:0]           mst_penable_i,
  input  logic [NrMasters-1:0]           mst_pwrite_i,
  input  logic [NrMasters*AddrWidth-1:0] mst_paddr_i,
  input  logic [NrMasters*DataWidth-1:0] mst_pwdata_i,
  output logic [NrMasters*DataWidth-1:0] mst_prdata_o,
  output logic [NrMasters-1:0]           mst_pready_o,
  output logic [NrMasters-1:0]           mst_pslverr_o,
  output logic                           slv_psel_o,
  output logic                           slv_penable_o,
  output logic                           slv_pwrite_o,
  output logic [AddrWidth-1:0]           slv_paddr_o,
  output logic [DataWidth-1:0]           slv_pwdata_o,
  input  logic [DataWidth-1:0]           slv_prdata_i,
  input  logic                           slv_pready_i,
  input  logic                           slv_pslverr_i,
  output logic                           arb_busy_o
);

  localparam int IdxW = (NrMasters > 1) ? $clog2(NrMasters) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                  state, state_next;
  logic [IdxW-1:0]         grant, grant_next;
  logic [IdxW-1:0]         rr_ptr, rr_ptr_next;
  logic [IdxW-1:0]         pick;
  logic                    found;
  logic                    done;
  logic                    timeout_hit;
  logic [2*NrMasters-1:0]  psel_rot;
  logic                    unused_inputs;

  // PENABLE from the masters carries no information the FSM needs
  assign unused_inputs = ^{mst_penable_i, (TimeoutCycles > 0)};

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW:0] v);
    logic [IdxW:0] w;
    if (v >= (IdxW+1)'(NrMasters)) begin
      w = v - (IdxW+1)'(NrMasters);
    end else begin
      w = v;
    end
    return w[IdxW-1:0];
  endfunction

  // Round-robin pick: rotate requests so rr_ptr lands on bit 0, take the first set bit
  always_comb begin
    psel_rot = {mst_psel_i, mst_psel_i} >> rr_ptr;
    found    = 1'b0;
    pick     = rr_ptr;
    for (int k = 0; k < NrMasters; k++) begin
      pick  = (!found && psel_rot[k]) ? wrap_idx({1'b0, rr_ptr} + (IdxW+1)'(k)) : pick;
      found = found | psel_rot[k];
    end
  end

`ifdef GPIO_APB_ARB_TIMEOUT_EN
  localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [TW-1:0] timer;

  assign timeout_hit = (timer == TW'(TimeoutCycles - 1)) && !slv_pready_i;

  // Count stalled ACCESS cycles; any other cycle leaves the timer at zero
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timer <= '0;
    end else if (state == ACCESS && !slv_pready_i && !timeout_hit) begin
      timer <= timer + TW'(1);
    end else begin
      timer <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Slave request mux and response demux; everything is silent in reset and IDLE
  always_comb begin
    slv_psel_o    = 1'b0;
    slv_penable_o = 1'b0;
    slv_pwrite_o  = 1'b0;
    slv_paddr_o   = '0;
    slv_pwdata_o  = '0;
    mst_prdata_o  = '0;
    mst_pready_o  = '0;
    mst_pslverr_o = '0;
    arb_busy_o    = 1'b0;
    done          = 1'b0;
    if (rst_ni && state != IDLE) begin
      arb_busy_o    = 1'b1;
      slv_psel_o    = 1'b1;
      slv_penable_o = (state == ACCESS);
      slv_pwrite_o  = mst_pwrite_i[grant];
      slv_paddr_o   = mst_paddr_i[int'(grant)*AddrWidth +: AddrWidth];
      slv_pwdata_o  = mst_pwdata_i[int'(grant)*DataWidth +: DataWidth];
      if (state == ACCESS && slv_pready_i) begin
        done                                              = 1'b1;
        mst_pready_o[grant]                               = 1'b1;
        mst_pslverr_o[grant]                              = slv_pslverr_i;
        mst_prdata_o[int'(grant)*DataWidth +: DataWidth]  = slv_prdata_i;
      end else if (state == ACCESS && timeout_hit) begin
        done                 = 1'b1;
        mst_pready_o[grant]  = 1'b1;
        mst_pslverr_o[grant] = 1'b1;
      end else begin
        done = 1'b0;
      end
    end else begin
      done = 1'b0;
    end
  end

  // Next-state logic for the IDLE -> SETUP -> ACCESS transfer sequence
  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_ptr_next = rr_ptr;
    case (state)
      IDLE: begin
        if (found) begin
          grant_next = pick;
          state_next = SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (done) begin
          rr_ptr_next = wrap_idx({1'b0, grant} + (IdxW+1)'(1));
          state_next  = IDLE;
        end else begin
          state_next = ACCESS;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
    end
  end

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Randomized bench for gpio_apb_arbiter: random masters, random wait-state slave,
// occasional protocol drops and resets, checked cycle by cycle against a transfer model.
module tb_gpio_apb_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [NM*AW-1:0] m_paddr;
  logic [NM*DW-1:0] m_pwdata, m_prdata;
  logic             s_psel, s_penable, s_pwrite, s_pready, s_pslverr, busy;
  logic [AW-1:0]    s_paddr;
  logic [DW-1:0]    s_pwdata, s_prdata;

  gpio_apb_arbiter #(
    .NrMasters(NM), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mst_psel_i(m_psel), .mst_penable_i(m_penable), .mst_pwrite_i(m_pwrite),
    .mst_paddr_i(m_paddr), .mst_pwdata_i(m_pwdata), .mst_prdata_o(m_prdata),
    .mst_pready_o(m_pready), .mst_pslverr_o(m_pslverr),
    .slv_psel_o(s_psel), .slv_penable_o(s_penable), .slv_pwrite_o(s_pwrite),
    .slv_paddr_o(s_paddr), .slv_pwdata_o(s_pwdata), .slv_prdata_i(s_prdata),
    .slv_pready_i(s_pready), .slv_pslverr_i(s_pslverr), .arb_busy_o(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Master-side request state and transfer-level model
  bit          req [NM];
  logic [31:0] addr [NM];
  logic [31:0] wdata [NM];
  bit          wr [NM];
  int owner    = -1;
  int phase    = 0;
  int waits    = 0;
  int rr       = 0;
  int wait_max = 4;

  task automatic cycle(input bit do_rst);
    logic          e_psel, e_pen, e_wr, e_busy;
    logic [31:0]   e_addr, e_wdata;
    logic [NM-1:0] e_pready, e_pslverr;
    logic [31:0]   e_prdata [NM];
    bit            abort_now, found;
    int            idx;
    @(negedge clk);
    for (int i = 0; i < NM; i++) begin
      if (!req[i] && i != owner && $urandom_range(0, 3) == 0) begin
        req[i]   = 1'b1;
        addr[i]  = $urandom;
        wdata[i] = $urandom;
        wr[i]    = 1'($urandom);
      end
    end
    if (owner >= 0 && req[owner] && $urandom_range(0, 29) == 0) req[owner] = 1'b0;
    for (int i = 0; i < NM; i++) begin
      m_psel[i]              = req[i];
      m_pwrite[i]            = wr[i];
      m_paddr[i*AW +: AW]    = addr[i];
      m_pwdata[i*DW +: DW]   = wdata[i];
    end
    m_penable = NM'($urandom);
    s_prdata  = $urandom;
    s_pslverr = 1'($urandom);
    s_pready  = (owner >= 0 && phase >= 1) ? (phase > waits) : 1'($urandom);
    rst_n     = !do_rst;
    #1;
    e_psel = 1'b0; e_pen = 1'b0; e_wr = 1'b0; e_busy = 1'b0;
    e_addr = '0; e_wdata = '0; e_pready = '0; e_pslverr = '0;
    abort_now = 1'b0;
    for (int i = 0; i < NM; i++) e_prdata[i] = '0;
    if (!do_rst && owner >= 0) begin
      e_psel = 1'b1; e_busy = 1'b1; e_pen = (phase >= 1);
      e_wr = wr[owner]; e_addr = addr[owner]; e_wdata = wdata[owner];
      if (phase >= 1 && s_pready) begin
        e_pready[owner]  = 1'b1;
        e_pslverr[owner] = s_pslverr;
        e_prdata[owner]  = s_prdata;
      end
`ifdef GPIO_APB_ARB_TIMEOUT_EN
      else if (phase == TO && !s_pready) begin
        abort_now        = 1'b1;
        e_pready[owner]  = 1'b1;
        e_pslverr[owner] = 1'b1;
      end
`endif
    end
    check_eq("slv_psel", 64'(s_psel), 64'(e_psel));
    check_eq("slv_penable", 64'(s_penable), 64'(e_pen));
    check_eq("slv_pwrite", 64'(s_pwrite), 64'(e_wr));
    check_eq("slv_paddr", 64'(s_paddr), 64'(e_addr));
    check_eq("slv_pwdata", 64'(s_pwdata), 64'(e_wdata));
    check_eq("arb_busy", 64'(busy), 64'(e_busy));
    check_eq("mst_pready", 64'(m_pready), 64'(e_pready));
    check_eq("mst_pslverr", 64'(m_pslverr), 64'(e_pslverr));
    for (int i = 0; i < NM; i++) check_eq($sformatf("mst_prdata%0d", i), 64'(m_prdata[i*DW +: DW]), 64'(e_prdata[i]));
    // Advance the model to what the next clock edge establishes
    if (do_rst) begin
      owner = -1;
      rr    = 0;
    end else if (owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < NM; k++) begin
        idx = (rr + k) % NM;
        if (!found && req[idx]) begin
          found = 1'b1;
          owner = idx;
          phase = 0;
          waits = $urandom_range(0, wait_max);
        end
      end
    end else if (phase == 0) begin
      phase = 1;
    end else if ((phase >= 1 && s_pready) || abort_now) begin
      req[owner] = 1'b0;
      rr         = (owner + 1) % NM;
      owner      = -1;
    end else begin
      phase++;
    end
  endtask

  initial begin
    for (int i = 0; i < NM; i++) begin
      req[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wr[i] = 1'b0;
    end
    m_psel = '0; m_penable = '0; m_pwrite = '0; m_paddr = '0; m_pwdata = '0;
    s_prdata = '0; s_pready = 1'b0; s_pslverr = 1'b0;
    repeat (3) cycle(1'b1);
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 99) == 0);
    end
`ifdef GPIO_APB_ARB_TIMEOUT_EN
    wait_max = 40;
    for (int n = 0; n < 400; n++) cycle(1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
